bmp_slice_streamer: RTL and testbench

- Parametrised successor to the fixed 24x64 bitmap register.
- Captures a COLS x ROWS bitmap in one load cycle.
- Streams it to the compare ALU over three independent valid/ready channels:
  - column slices, descending;
  - top row slices, descending;
  - bottom row slices, ascending.
- Sits between the bitmap source and the compare accumulator ALU. It replaces pulse-driven "next" inputs with proper backpressure, and adds slice indices and a completion pulse.

---
 rtl/bmp_slice_streamer_if.sv | 49 ++++
 rtl/bmp_slice_streamer.sv | 206 ++++++++++++++++++++
 tb/tb_bmp_slice_streamer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmp_slice_streamer_if.sv
// Load and slice-stream bundle for bmp_slice_streamer: bitmap load strobe, three
// valid/ready slice channels (column, top row, bottom row) plus busy/done status.
interface bmp_slice_streamer_if #(
  parameter int COLS = 24,
  parameter int ROWS = 64
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic                 wren;
  logic [COLS*ROWS-1:0] bmpin;

  logic [ROWS-1:0]      col_data;
  logic [CW-1:0]        col_idx;
  logic                 col_valid;
  logic                 col_ready;
  logic                 col_last;

  logic [COLS-1:0]      top_data;
  logic [RW-1:0]        top_idx;
  logic                 top_valid;
  logic                 top_ready;
  logic                 top_last;

  logic [COLS-1:0]      bot_data;
  logic [RW-1:0]        bot_idx;
  logic                 bot_valid;
  logic                 bot_ready;
  logic                 bot_last;

  logic                 busy;
  logic                 done;

  modport master (
    input  wren, bmpin, col_ready, top_ready, bot_ready,
    output col_data, col_idx, col_valid, col_last,
    output top_data, top_idx, top_valid, top_last,
    output bot_data, bot_idx, bot_valid, bot_last,
    output busy, done
  );

  modport slave (
    output wren, bmpin, col_ready, top_ready, bot_ready,
    input  col_data, col_idx, col_valid, col_last,
    input  top_data, top_idx, top_valid, top_last,
    input  bot_data, bot_idx, bot_valid, bot_last,
    input  busy, done
  );
endinterface

// File: rtl/bmp_slice_streamer.sv
// Captures a COLS x ROWS bitmap and streams column / top-row / bottom-row slices.
// Optional macro BMP_SLICE_STREAMER_ZERO_SKIP_EN: column stream skips all-zero columns.
module bmp_slice_streamer #(
  parameter int COLS = 24,
  parameter int ROWS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  bmp_slice_streamer_if.master  bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int N  = COLS * ROWS;
  localparam logic [CW:0]   COL_LIM = (CW+1)'(COLS);
  localparam logic [RW-1:0] ROW_TOP = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_PEN = RW'(ROWS - 2);

  logic [N-1:0]    bmp_r, bmp_s;
  logic [ROWS-1:0] col_data_r, col_data_s;
  logic [CW-1:0]   col_idx_r, col_idx_s;
  logic            col_valid_r, col_valid_s, col_last_r, col_last_s;
  logic [COLS-1:0] top_data_r, top_data_s, bot_data_r, bot_data_s;
  logic [RW-1:0]   top_idx_r, top_idx_s, bot_idx_r, bot_idx_s;
  logic            top_valid_r, top_valid_s, top_last_r, top_last_s;
  logic            bot_valid_r, bot_valid_s, bot_last_r, bot_last_s;
  logic            busy_r, busy_s, busy_d_r, done_r, done_s;
  logic [COLS-1:0] mask_s;
  logic [CW:0]     search_lim_s, first_s, second_s;

  function automatic logic [ROWS-1:0] col_slice(input logic [N-1:0] b, input logic [CW-1:0] c);
    logic [ROWS-1:0] s;
    s = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < COLS; k++) begin
        if (k == int'(c)) s[ROWS-1-r] = b[r*COLS + k];
      end
    end
    return s;
  endfunction

  function automatic logic [COLS-1:0] row_slice(input logic [N-1:0] b, input logic [RW-1:0] r);
    logic [COLS-1:0] s;
    s = '0;
    for (int k = 0; k < ROWS; k++) begin
      if (k == int'(r)) s = b[k*COLS +: COLS];
    end
    return s;
  endfunction

`ifdef BMP_SLICE_STREAMER_ZERO_SKIP_EN
  function automatic logic [COLS-1:0] col_mask(input logic [N-1:0] b);
    logic [COLS-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) m[c] = m[c] | b[r*COLS + c];
    end
    return m;
  endfunction
`endif

  // Highest candidate column strictly below lim; MSB of the result flags a hit.
  function automatic logic [CW:0] hi_below(input logic [COLS-1:0] m, input logic [CW:0] lim);
    logic [CW:0] res;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      if (m[c] && (c < int'(lim))) res = {1'b1, CW'(c)};
    end
    return res;
  endfunction

  // Next-state computation: load wins over transfers, each channel advances alone.
  always_comb begin
    bmp_s       = bmp_r;
    col_data_s  = col_data_r;
    col_idx_s   = col_idx_r;
    col_valid_s = col_valid_r;
    col_last_s  = col_last_r;
    top_data_s  = top_data_r;
    top_idx_s   = top_idx_r;
    top_valid_s = top_valid_r;
    top_last_s  = top_last_r;
    bot_data_s  = bot_data_r;
    bot_idx_s   = bot_idx_r;
    bot_valid_s = bot_valid_r;
    bot_last_s  = bot_last_r;
`ifdef BMP_SLICE_STREAMER_ZERO_SKIP_EN
    mask_s = col_mask(bus.wren ? bus.bmpin : bmp_r);
`else
    mask_s = '1;
`endif
    search_lim_s = bus.wren ? COL_LIM : {1'b0, col_idx_r};
    first_s      = hi_below(mask_s, search_lim_s);
    second_s     = hi_below(mask_s, {1'b0, first_s[CW-1:0]});

    if (bus.wren) begin
      bmp_s       = bus.bmpin;
      col_valid_s = first_s[CW];
      col_idx_s   = first_s[CW-1:0];
      col_last_s  = first_s[CW] & ~second_s[CW];
      col_data_s  = col_slice(bus.bmpin, first_s[CW-1:0]);
      top_valid_s = 1'b1;
      top_idx_s   = ROW_TOP;
      top_last_s  = 1'b0;
      top_data_s  = row_slice(bus.bmpin, ROW_TOP);
      bot_valid_s = 1'b1;
      bot_idx_s   = '0;
      bot_last_s  = 1'b0;
      bot_data_s  = row_slice(bus.bmpin, '0);
    end else begin
      if (col_valid_r && bus.col_ready) begin
        if (col_last_r) begin
          col_valid_s = 1'b0;
          col_last_s  = 1'b0;
        end else begin
          col_idx_s  = first_s[CW-1:0];
          col_last_s = ~second_s[CW];
          col_data_s = col_slice(bmp_r, first_s[CW-1:0]);
        end
      end else begin
        col_valid_s = col_valid_r;
      end
      if (top_valid_r && bus.top_ready) begin
        if (top_last_r) begin
          top_valid_s = 1'b0;
          top_last_s  = 1'b0;
        end else begin
          top_idx_s  = top_idx_r - RW'(1);
          top_last_s = (top_idx_r == RW'(1));
          top_data_s = row_slice(bmp_r, top_idx_r - RW'(1));
        end
      end else begin
        top_valid_s = top_valid_r;
      end
      if (bot_valid_r && bus.bot_ready) begin
        if (bot_last_r) begin
          bot_valid_s = 1'b0;
          bot_last_s  = 1'b0;
        end else begin
          bot_idx_s  = bot_idx_r + RW'(1);
          bot_last_s = (bot_idx_r == ROW_PEN);
          bot_data_s = row_slice(bmp_r, bot_idx_r + RW'(1));
        end
      end else begin
        bot_valid_s = bot_valid_r;
      end
    end

    busy_s = col_valid_s | top_valid_s | bot_valid_s;
    // A reload keeps busy high, so an aborted bitmap never produces a falling edge.
    done_s = busy_d_r & ~busy_r;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bmp_r       <= '0;
      col_data_r  <= '0;
      col_idx_r   <= '0;
      col_valid_r <= 1'b0;
      col_last_r  <= 1'b0;
      top_data_r  <= '0;
      top_idx_r   <= '0;
      top_valid_r <= 1'b0;
      top_last_r  <= 1'b0;
      bot_data_r  <= '0;
      bot_idx_r   <= '0;
      bot_valid_r <= 1'b0;
      bot_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      busy_d_r    <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      bmp_r       <= bmp_s;
      col_data_r  <= col_data_s;
      col_idx_r   <= col_idx_s;
      col_valid_r <= col_valid_s;
      col_last_r  <= col_last_s;
      top_data_r  <= top_data_s;
      top_idx_r   <= top_idx_s;
      top_valid_r <= top_valid_s;
      top_last_r  <= top_last_s;
      bot_data_r  <= bot_data_s;
      bot_idx_r   <= bot_idx_s;
      bot_valid_r <= bot_valid_s;
      bot_last_r  <= bot_last_s;
      busy_r      <= busy_s;
      busy_d_r    <= busy_r;
      done_r      <= done_s;
    end
  end

  assign bus.col_data  = col_data_r;
  assign bus.col_idx   = col_idx_r;
  assign bus.col_valid = col_valid_r;
  assign bus.col_last  = col_last_r;
  assign bus.top_data  = top_data_r;
  assign bus.top_idx   = top_idx_r;
  assign bus.top_valid = top_valid_r;
  assign bus.top_last  = top_last_r;
  assign bus.bot_data  = bot_data_r;
  assign bus.bot_idx   = bot_idx_r;
  assign bus.bot_valid = bot_valid_r;
  assign bus.bot_last  = bot_last_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_bmp_slice_streamer.sv
// Directed bench for bmp_slice_streamer: a vector table for load/backpressure steps
// plus hand-written sequences for full runs, stalls, abort, async reset and zero skip.
module tb_bmp_slice_streamer;
  localparam int COLS = 24;
  localparam int ROWS = 64;
  localparam int N    = COLS * ROWS;
`ifdef BMP_SLICE_STREAMER_ZERO_SKIP_EN
  localparam int P_NCOL  = 6;
  localparam int Z_NCOL  = 2;
  localparam int Z_FIRST = 20;
  localparam int Z_SECOND = 3;
  localparam int ZERO_VALID = 0;
`else
  localparam int P_NCOL  = 24;
  localparam int Z_NCOL  = 24;
  localparam int Z_FIRST = 23;
  localparam int Z_SECOND = 22;
  localparam int ZERO_VALID = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  bmp_slice_streamer_if #(.COLS(COLS), .ROWS(ROWS)) bus ();
  bmp_slice_streamer #(.COLS(COLS), .ROWS(ROWS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_col, m_top, m_bot, done_count, ccount, tcount, bcount;
  logic [N-1:0] m_bmp, pat_p, pat_b, pat_z;

  typedef struct {
    logic wr, cr, tr, br;
    int   ecol, etop, ebot;
  } vec_t;
  vec_t tbl [9];

  function automatic logic [ROWS-1:0] exp_col_data(input logic [N-1:0] b, input int c);
    logic [ROWS-1:0] s;
    for (int r = 0; r < ROWS; r++) s[ROWS-1-r] = b[r*COLS + c];
    return s;
  endfunction

  function automatic logic [COLS-1:0] exp_row(input logic [N-1:0] b, input int r);
    return b[r*COLS +: COLS];
  endfunction

  // Next column the stream should present below 'from' for the modelled bitmap.
  function automatic int next_col(input int from);
`ifdef BMP_SLICE_STREAMER_ZERO_SKIP_EN
    for (int c = from - 1; c >= 0; c--) begin
      if (exp_col_data(m_bmp, c) != '0) return c;
    end
    return -1;
`else
    return from - 1;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_idle();
    m_col = -1;
    m_top = -1;
    m_bot = ROWS;
  endtask

  // Compare outputs against the model, drive one cycle of inputs, advance the model.
  task automatic cycle(input logic cr, input logic tr, input logic br, input logic wr,
                       input logic [N-1:0] nb);
    chk("col_valid", 64'(bus.col_valid), 64'(m_col >= 0));
    if (m_col >= 0) begin
      chk("col_idx", 64'(bus.col_idx), 64'(m_col));
      chk("col_data", 64'(bus.col_data), 64'(exp_col_data(m_bmp, m_col)));
      chk("col_last", 64'(bus.col_last), 64'(next_col(m_col) < 0));
    end
    chk("top_valid", 64'(bus.top_valid), 64'(m_top >= 0));
    if (m_top >= 0) begin
      chk("top_idx", 64'(bus.top_idx), 64'(m_top));
      chk("top_data", 64'(bus.top_data), 64'(exp_row(m_bmp, m_top)));
      chk("top_last", 64'(bus.top_last), 64'(m_top == 0));
    end
    chk("bot_valid", 64'(bus.bot_valid), 64'(m_bot < ROWS));
    if (m_bot < ROWS) begin
      chk("bot_idx", 64'(bus.bot_idx), 64'(m_bot));
      chk("bot_data", 64'(bus.bot_data), 64'(exp_row(m_bmp, m_bot)));
      chk("bot_last", 64'(bus.bot_last), 64'(m_bot == ROWS - 1));
    end
    chk("busy", 64'(bus.busy), 64'((m_col >= 0) || (m_top >= 0) || (m_bot < ROWS)));
    if (bus.done) done_count++;
    bus.col_ready = cr;
    bus.top_ready = tr;
    bus.bot_ready = br;
    bus.wren      = wr;
    if (wr) begin
      bus.bmpin = nb;
      m_bmp = nb;
      m_col = next_col(COLS);
      m_top = ROWS - 1;
      m_bot = 0;
    end else begin
      if (m_col >= 0 && cr) begin m_col = next_col(m_col); ccount++; end
      if (m_top >= 0 && tr) begin m_top--; tcount++; end
      if (m_bot < ROWS && br) begin m_bot++; bcount++; end
    end
    @(posedge clk);
    #1;
    bus.wren = 1'b0;
  endtask

  task automatic run_to_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!bus.busy) break;
      cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    end
    chk("reach_idle", 64'(bus.busy), 64'(0));
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int col_end, top_end, nseen, z0, z1;
    bus.wren = 1'b0; bus.bmpin = '0;
    bus.col_ready = 1'b0; bus.top_ready = 1'b0; bus.bot_ready = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      pat_p[r*COLS +: COLS] = COLS'(r);
      pat_b[r*COLS +: COLS] = ~COLS'(r);
    end
    pat_z = '0;
    pat_z[5*COLS + 20]  = 1'b1;
    pat_z[10*COLS + 3]  = 1'b1;
    pat_z[63*COLS + 3]  = 1'b1;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 23, 63, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 22, 62, 1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 21, 62, 2};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 21, 62, 2};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 21, 61, 2};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 23, 63, 0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 22, 63, 0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 22, 63, 1};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 22, 62, 2};
    m_bmp = '0; ccount = 0; tcount = 0; bcount = 0; done_count = 0;
    model_idle();

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_col_valid", 64'(bus.col_valid), 64'(0));
    chk("rst_top_valid", 64'(bus.top_valid), 64'(0));
    chk("rst_bot_valid", 64'(bus.bot_valid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_col_idx", 64'(bus.col_idx), 64'(0));
    chk("rst_top_idx", 64'(bus.top_idx), 64'(0));
    chk("rst_bot_idx", 64'(bus.bot_idx), 64'(0));
    chk("rst_col_last", 64'(bus.col_last), 64'(0));
    repeat (4) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("idle_no_done", 64'(done_count), 64'(0));

    bus.bmpin = pat_b;
    for (int i = 0; i < 9; i++) begin
      bus.wren      = tbl[i].wr;
      bus.col_ready = tbl[i].cr;
      bus.top_ready = tbl[i].tr;
      bus.bot_ready = tbl[i].br;
      @(posedge clk);
      #1;
      chk("tbl_col_valid", 64'(bus.col_valid), 64'(1));
      chk("tbl_col_idx", 64'(bus.col_idx), 64'(tbl[i].ecol));
      chk("tbl_col_data", 64'(bus.col_data), 64'(exp_col_data(pat_b, tbl[i].ecol)));
      chk("tbl_col_last", 64'(bus.col_last), 64'(0));
      chk("tbl_top_idx", 64'(bus.top_idx), 64'(tbl[i].etop));
      chk("tbl_top_data", 64'(bus.top_data), 64'(exp_row(pat_b, tbl[i].etop)));
      chk("tbl_bot_idx", 64'(bus.bot_idx), 64'(tbl[i].ebot));
      chk("tbl_bot_data", 64'(bus.bot_data), 64'(exp_row(pat_b, tbl[i].ebot)));
      chk("tbl_busy", 64'(bus.busy), 64'(1));
      chk("tbl_done", 64'(bus.done), 64'(0));
    end
    bus.wren = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_idle();

    // Full run with every consumer always ready.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, pat_p);
    done_count = 0; ccount = 0;
    repeat (64) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("full_busy_fall", 64'(bus.busy), 64'(0));
    chk("full_done_early", 64'(bus.done), 64'(0));
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("full_done_pulse", 64'(bus.done), 64'(1));
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("full_done_clear", 64'(bus.done), 64'(0));
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("full_done_count", 64'(done_count), 64'(1));
    chk("full_col_count", 64'(ccount), 64'(P_NCOL));

    // Column ready toggling, top ready held low for the first 10 cycles.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, pat_p);
    col_end = -1; top_end = -1; ccount = 0; tcount = 0; bcount = 0; done_count = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (col_end < 0 && !bus.col_valid) col_end = cyc;
      if (top_end < 0 && !bus.top_valid) top_end = cyc;
      if (!bus.busy) break;
      cycle(cyc % 2 == 0, cyc >= 10, 1'b1, 1'b0, '0);
    end
    chk("stall_col_end", 64'(col_end), 64'(2 * P_NCOL - 1));
    chk("stall_top_end", 64'(top_end), 64'(74));
    chk("stall_col_count", 64'(ccount), 64'(P_NCOL));
    chk("stall_top_count", 64'(tcount), 64'(64));
    chk("stall_bot_count", 64'(bcount), 64'(64));
    run_to_idle(10);
    chk("stall_done_count", 64'(done_count), 64'(1));

    // Abort: reload with B after five column transfers of A.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, pat_p);
    done_count = 0;
    repeat (5) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, pat_b);
    chk("abort_col_idx", 64'(bus.col_idx), 64'(23));
    chk("abort_col_data", 64'(bus.col_data), 64'(exp_col_data(pat_b, 23)));
    chk("abort_top_idx", 64'(bus.top_idx), 64'(63));
    chk("abort_no_done", 64'(done_count), 64'(0));
    run_to_idle(100);
    chk("abort_done_count", 64'(done_count), 64'(1));

    // Asynchronous reset between edges in the middle of a stream.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, pat_p);
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    done_count = 0;
    #3 rst = 1'b1;
    #1;
    chk("arst_col_valid", 64'(bus.col_valid), 64'(0));
    chk("arst_top_valid", 64'(bus.top_valid), 64'(0));
    chk("arst_bot_valid", 64'(bus.bot_valid), 64'(0));
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_top_idx", 64'(bus.top_idx), 64'(0));
    chk("arst_top_data", 64'(bus.top_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_idle();
    repeat (70) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("arst_no_done", 64'(done_count), 64'(0));

    // Sparse bitmap: only columns 20 and 3 carry ones.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, pat_z);
    ccount = 0; done_count = 0; nseen = 0; z0 = -1; z1 = -1;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) break;
      if (bus.col_valid) begin
        if (nseen == 0) z0 = int'(bus.col_idx);
        else if (nseen == 1) z1 = int'(bus.col_idx);
        nseen++;
      end
      cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    end
    chk("sparse_col_count", 64'(ccount), 64'(Z_NCOL));
    chk("sparse_first_idx", 64'(z0), 64'(Z_FIRST));
    chk("sparse_second_idx", 64'(z1), 64'(Z_SECOND));
    run_to_idle(10);
    chk("sparse_done_count", 64'(done_count), 64'(1));

    // All-zero bitmap.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    done_count = 0;
    chk("zero_col_valid", 64'(bus.col_valid), 64'(ZERO_VALID));
    chk("zero_top_valid", 64'(bus.top_valid), 64'(1));
    run_to_idle(100);
    chk("zero_done_count", 64'(done_count), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
